// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus request/response types and arbiter state encoding.
package dbus_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef logic [0:0] dbarb_state_t;

    localparam dbarb_state_t DBARB_IDLE = 1'b0;
    localparam dbarb_state_t DBARB_BUSY = 1'b1;

endpackage

// File: rtl/dbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index scanning circularly from i_last+1.
module dbus_arbiter_rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_valid,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_any,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_cand;

    // Walk from the farthest candidate back to last+1 so the nearest valid one wins.
    always_comb begin
        o_any  = |i_valid;
        o_idx  = '0;
        w_cand = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(i_last) + k) % NREQ);
            if (i_valid[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing one data-bus port among NREQ requesters.
//   state | meaning
//   IDLE  | no owner; oreq/iresps zero; arbitrate among valid requests
//   BUSY  | r_req_q drives oreq; oresp routed to the granted requester only
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  dbus_req_t        ireqs  [NREQ],
    output dbus_resp_t       iresps [NREQ],
    output dbus_req_t        oreq,
    input  dbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);

    dbarb_state_t     r_state;
    dbus_req_t        r_req_q;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_last;

    logic [NREQ-1:0]  w_valid;
    logic             w_any;
    logic [IDX_W-1:0] w_pick;

    always_comb begin
        w_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_valid[i] = ireqs[i].valid;
        end
    end

    dbus_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_valid (w_valid),
        .i_last  (r_last),
        .o_any   (w_any),
        .o_idx   (w_pick)
    );

    // last starts at NREQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= DBARB_IDLE;
            r_req_q     <= '0;
            r_grant_idx <= '0;
            r_last      <= IDX_W'(NREQ - 1);
        end else begin
            case (r_state)
                DBARB_IDLE: begin
                    if (w_any) begin
                        r_req_q     <= ireqs[w_pick];
                        r_grant_idx <= w_pick;
                        r_state     <= DBARB_BUSY;
                    end
                end
                DBARB_BUSY: begin
                    if (oresp.data_ok) begin
                        r_last  <= r_grant_idx;
                        r_state <= DBARB_IDLE;
                    end
                end
                default: r_state <= DBARB_IDLE;
            endcase
        end
    end

    always_comb begin
        oreq = '0;
        if (r_state == DBARB_BUSY) begin
            oreq       = r_req_q;
            oreq.valid = 1'b1;
        end
    end

    // Only the owner sees oresp; a stray response while IDLE goes nowhere.
    always_comb begin
        for (int j = 0; j < NREQ; j++) begin
            iresps[j] = '0;
            if ((r_state == DBARB_BUSY) && (r_grant_idx == IDX_W'(j))) begin
                iresps[j] = oresp;
            end
        end
    end

    assign busy      = (r_state == DBARB_BUSY);
    assign grant_idx = r_grant_idx;

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Shares the core's single data-bus port (`dbus_req_t`/`dbus_resp_t`) between NREQ requesters: the load/store unit, the page-table walker that consumes `satp`/`mode`, and spare slots. It sits between those requesters and `DBusToCBus`. It grants one requester at a time with round-robin priority, and latches the granted request so the downstream request stays stable for the whole transaction. Responses are routed back only to the granted requester.

## Interface
Parameters:
- NREQ, 2: number of requesters; legal range 2..4.
- IDX_W, $clog2(NREQ): width of the grant index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset. The block is in reset while `reset == 0` at a rising `clk` edge.
- ireqs  in  NREQ x dbus_req_t  requests from the requesters. Index 0 has the highest initial priority.
- iresps  out  NREQ x dbus_resp_t  responses to the requesters.
- oreq  out  dbus_req_t  request to the downstream bus.
- oresp  in  dbus_resp_t  response from the downstream bus.
- busy  out  1  high while a transaction is owned.
- grant_idx  out  IDX_W  index of the current or last owner.

## Operation
- States: IDLE and BUSY.
- IDLE:
  - `oreq.valid = 0`.
  - All `iresps` are zero.
  - If any `ireqs[i].valid` is set, pick the first valid index scanning circularly from `last+1`.
  - At the clock edge: latch the whole `ireqs[i]` into `req_q`, set `grant_idx = i`, and go to BUSY.
- BUSY:
  - `oreq = req_q` with `valid = 1`.
  - `iresps[grant_idx] = oresp`, passed through combinationally.
  - Every other `iresps[j]` is zero.
  - On `oresp.data_ok`: set `last = grant_idx` and return to IDLE at the next edge.
- Protocol: a requester holds `valid` and the payload until it sees `data_ok`. The arbiter ignores any change on the granted `ireqs` while BUSY, because `req_q` is authoritative.
- `addr_ok` is forwarded as-is. Receiving `addr_ok` does not end ownership; only `data_ok` does.
- Non-granted requesters stay pending, seeing `addr_ok = data_ok = 0`, until they are granted.

## Timing
- Reset values:
  - state = IDLE.
  - `last = NREQ-1`, so index 0 wins the first arbitration.
  - `req_q = '0`, `grant_idx = 0`, `busy = 0`.
  - `oreq = '0`, all `iresps = '0`.
- Grant latency: `valid` seen in IDLE at edge k gives `oreq.valid = 1` from cycle k+1.
- Response latency through the arbiter: 0 cycles.
- Turnaround: `data_ok` in cycle m puts the arbiter in IDLE in cycle m+1, so the next `oreq.valid` is at m+2. There is exactly one dead cycle between transactions.
- `data_ok` in the same cycle the request is first presented: legal. Ownership ends after that single BUSY cycle.
- Simultaneous requests: the round-robin order decides. With two requesters held valid continuously, grants strictly alternate.
- A requester that drops `valid` in IDLE before being granted is not granted.
- Reset asserted mid-transaction:
  - Returns to IDLE next cycle and drops `oreq.valid`.
  - A late `data_ok` arriving in IDLE is not forwarded to anyone.
- `last` wraps modulo NREQ.

## Structure
- The state enum (`IDLE`, `BUSY`) lives in the shared `pipes` package as `dbarb_state_t`. `NREQ` stays a local parameter.
- One sub-module is natural: `rr_pick`. It is combinational: inputs are the valid vector and `last`; outputs are the `any` flag and the picked index.
- The `dbus_req_t` and `dbus_resp_t` types come from `common`.

## Test plan
- Single request: hold reset low for 2 cycles. Then `ireqs[0] = {valid, addr 0x80000000}`. Expect:
  - `oreq.valid = 1` one cycle later with addr `0x80000000`.
  - `data_ok` after 3 cycles is seen only on `iresps[0]`.
  - `busy` falls the next cycle.
- Contention: `ireqs[0]` and `ireqs[1]` both valid and held. Expect the grant order 0, 1, 0, 1 with one idle cycle between grants.
- Payload stability: after the grant, change `ireqs[0].addr` to `0x1234`. Expect `oreq.addr` to stay at the latched value until `data_ok`.
- Same-cycle `data_ok`: `oresp` returns `addr_ok = data_ok = 1` in the first BUSY cycle. Expect `iresps[0].data_ok` pulses once and the arbiter is IDLE the next cycle.
- Reset mid-transaction: assert reset while BUSY, then release. Expect:
  - `oreq.valid = 0` and grant index 0 after release.
  - A stray `data_ok` arriving while IDLE is not forwarded to any requester.
- NREQ = 3: all three requesters held valid. Expect the grant order 0, 1, 2, 0, showing the round-robin wrap-around.
